// File: rtl/servo_cmd_pkg.sv
// Shared types and defaults for the servo command receiver.
package servo_cmd_pkg;
  localparam int DEFAULT_WIDTH   = 10;
  localparam int DEFAULT_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    READY = 2'd0,
    ACK   = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead instruction FIFO; head word is visible whenever non-empty.
module cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_eff, push_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/servo_cmd_rx.sv
// Serial instruction receiver: 4-phase bit handshake from MBED into a FIFO,
// with frame clear and idle timeout for abandoned partial frames.
module servo_cmd_rx
  import servo_cmd_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data_bit,
  input  logic                   confirm_bit,
  input  logic                   clear,
  output logic                   data_ready,
  output logic [WIDTH-1:0]       instr_data,
  output logic                   instr_valid,
  input  logic                   instr_pop,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err,
  input  logic                   err_clr
);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);

  logic [2:0]       sync1, sync2;
  logic             dsync, csync, clrsync;
  rx_state_e        state;
  logic [WIDTH-1:0] shreg, word, push_data;
  logic [BCW-1:0]   bit_cnt;
  logic [ICW-1:0]   idle_cnt;
  logic             fifo_full, fifo_empty, pop_eff, space, last_bit;
  logic             push, stay, idle_run, timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {data_bit, confirm_bit, clear};
      sync2 <= sync1;
    end
  end
  assign {dsync, csync, clrsync} = sync2;

  assign pop_eff  = instr_pop && !fifo_empty;
  assign space    = !fifo_full || pop_eff;
  assign last_bit = (bit_cnt == BCW'(WIDTH - 1));
  assign word     = {shreg[WIDTH-2:0], dsync};

  always_comb begin
    push      = 1'b0;
    push_data = word;
    stay      = 1'b1;
    case (state)
      READY: if (csync) begin
        stay = 1'b0;
        if (!clrsync && last_bit && space) push = 1'b1;
      end
      ACK:   if (!csync) stay = 1'b0;
      HOLD: begin
        push_data = shreg;
        if (space) begin
          push = 1'b1;
          stay = 1'b0;
        end
      end
      default: stay = 1'b0;
    endcase
  end

  // Idle counter only watches partial frames and restarts on any transition.
  assign idle_run    = stay && (state != HOLD) && (bit_cnt != '0);
  assign timeout_hit = idle_run && (idle_cnt == ICW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= READY;
      data_ready  <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        READY: if (csync) begin
          data_ready <= 1'b0;
          if (clrsync) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= ACK;
          end else if (last_bit) begin
            bit_cnt <= '0;
            if (space) begin
              shreg <= '0;
              state <= ACK;
            end else begin
              shreg <= word;
              state <= HOLD;
            end
          end else begin
            shreg   <= word;
            bit_cnt <= bit_cnt + 1'b1;
            state   <= ACK;
          end
        end
        ACK: if (!csync) begin
          state      <= READY;
          data_ready <= 1'b1;
        end
        HOLD: if (space) begin
          shreg      <= '0;
          state      <= csync ? ACK : READY;
          data_ready <= !csync;
        end
        default: begin
          state      <= READY;
          data_ready <= 1'b1;
        end
      endcase
      // Timeout wins over err_clr and leaves the FSM state alone.
      if (!idle_run) begin
        idle_cnt <= '0;
      end else if (timeout_hit) begin
        idle_cnt    <= '0;
        shreg       <= '0;
        bit_cnt     <= '0;
        timeout_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_pop),
    .pop_data  (instr_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
endmodule

// File: tb/tb_servo_cmd_rx.sv
// Directed bench for servo_cmd_rx with default parameters.
module tb_servo_cmd_rx;
  logic       clk = 1'b0;
  logic       reset_n, data_bit, confirm_bit, clear, instr_pop, err_clr;
  logic       data_ready, instr_valid, timeout_err;
  logic [9:0] instr_data;
  logic [2:0] fifo_count;
  int         total = 0;
  int         bad   = 0;

  servo_cmd_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_bit    (data_bit),
    .confirm_bit (confirm_bit),
    .clear       (clear),
    .data_ready  (data_ready),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .instr_pop   (instr_pop),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; data_bit = 1'b0; confirm_bit = 1'b0; clear = 1'b0;
    instr_pop = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (data_ready !== 1'b1 || instr_valid !== 1'b0 || instr_data !== 10'h000 ||
        fifo_count !== 3'd0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: dr=%b valid=%b data=%h cnt=%0d terr=%b, want 1 0 000 0 0",
               tag, data_ready, instr_valid, instr_data, fifo_count, timeout_err);
    end
  endtask

  // mode 0: normal handshake, 1: expect HOLD after sample, 2: pop on the sample edge
  task automatic send_bit(input logic b, input logic clr, input int mode);
    bit ok;
    bit seen;
    ok = 1'b1;
    @(negedge clk);
    data_bit = b; clear = clr; confirm_bit = 1'b1;
    @(posedge clk); #1 if (data_ready !== 1'b1) ok = 1'b0;
    @(posedge clk); #1 if (data_ready !== 1'b1) ok = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      instr_pop = 1'b1;
    end
    @(posedge clk); #1 if (data_ready !== 1'b0) ok = 1'b0;
    instr_pop = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_fall: data_ready did not fall on edge 3 (now %b, want 0)", data_ready);
    end
    @(negedge clk);
    confirm_bit = 1'b0; clear = 1'b0;
    if (mode == 1) begin
      repeat (8) @(posedge clk);
      #1 total++;
      if (data_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready: data_ready=%b want 0", data_ready);
      end
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(posedge clk); #1 if (data_ready === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL ready_rise: data_ready=%b want 1 within 10 cycles", data_ready);
      end
    end
  endtask

  task automatic send_word(input logic [9:0] w, input int last_mode);
    for (int i = 9; i >= 0; i--) send_bit(w[i], 1'b0, (i == 0) ? last_mode : 0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    instr_pop = 1'b1;
    @(posedge clk); #1
    instr_pop = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [9:0] d, input logic [2:0] c);
    total++;
    if (instr_data !== d || fifo_count !== c || instr_valid !== (c != 0)) begin
      bad++;
      $display("FAIL %s: data=%h cnt=%0d valid=%b, want data=%h cnt=%0d", tag,
               instr_data, fifo_count, instr_valid, d, c);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1 check_idle_outputs("reset_state");
  endtask

  task automatic test_basic_word();
    send_word(10'b1011001110, 0);
    check_head("basic_word", 10'h2CE, 3'd1);
    pop_one();
    check_head("basic_pop", 10'h000, 3'd0);
  endtask

  task automatic test_hold();
    send_word(10'h001, 0);
    send_word(10'h155, 0);
    send_word(10'h2AA, 0);
    send_word(10'h3C3, 0);
    check_head("fill4", 10'h001, 3'd4);
    send_word(10'h0F0, 1);
    check_head("held_no_push", 10'h001, 3'd4);
    pop_one();
    check_head("hold_release", 10'h155, 3'd4);
    total++;
    if (data_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_ready_back: data_ready=%b want 1", data_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_word(10'h111, 2);
    check_head("full_push_pop", 10'h2AA, 3'd4);
    pop_one(); check_head("drain1", 10'h3C3, 3'd3);
    pop_one(); check_head("drain2", 10'h0F0, 3'd2);
    pop_one(); check_head("drain3", 10'h111, 3'd1);
    pop_one(); check_head("drain4", 10'h000, 3'd0);
  endtask

  task automatic test_timeout();
    bit seen;
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL early_timeout: timeout_err=%b want 0", timeout_err);
    end
    seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(posedge clk); #1 if (timeout_err === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL timeout_set: terr=%b cnt=%0d want 1 0", timeout_err, fifo_count);
    end
    send_word(10'h1A5, 0);
    check_head("after_timeout", 10'h1A5, 3'd1);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: terr=%b want 1", timeout_err);
    end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: terr=%b want 0", timeout_err);
    end
    pop_one();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 6; i++) send_bit(i[0], 1'b0, 0);
    send_bit(1'b1, 1'b1, 0);
    check_head("clear_no_push", 10'h000, 3'd0);
    send_word(10'h3FF, 0);
    check_head("clear_then_word", 10'h3FF, 3'd1);
    pop_one();
  endtask

  task automatic test_reset_mid();
    send_word(10'h011, 0);
    send_word(10'h022, 0);
    send_word(10'h033, 0);
    send_word(10'h044, 0);
    send_word(10'h055, 1);
    do_reset();
    #1 check_idle_outputs("reset_in_hold");
    repeat (5) @(posedge clk);
    #1 check_idle_outputs("no_stale_hold");
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    do_reset();
    #1 check_idle_outputs("reset_mid_frame");
    send_word(10'h0AB, 0);
    check_head("word_after_reset", 10'h0AB, 3'd1);
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_hold();
    test_back_to_back();
    test_timeout();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
